// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and address field helpers for the direct-mapped
// instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned SETS   = 64;

  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned WORD_W = $clog2(LINE_W / DATA_W);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned SEL_W  = $clog2(LINE_W);
  localparam int unsigned BSEL_W = $clog2(DATA_W);

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissWait,
    StResp
  } state_e;

  function automatic logic [TAG_W-1:0] get_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_idx(input addr_t a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [WORD_W-1:0] get_word(input addr_t a);
    return a[OFF_W-1 -: WORD_W];
  endfunction

  function automatic addr_t line_addr(input addr_t a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake signals of the instruction cache.
interface icache_if;
  import icache_pkg::*;

  logic              up_req_valid;
  logic              up_req_ready;
  logic [ADDR_W-1:0] up_req_addr;
  logic              up_resp_valid;
  logic [DATA_W-1:0] up_resp_data;
  logic              up_flush;
  logic              down_req_valid;
  logic              down_req_ready;
  logic [ADDR_W-1:0] down_req_addr;
  logic              down_resp_valid;
  logic [LINE_W-1:0] down_resp_data;

  // Cache side.
  modport slave (
    input  up_req_valid, up_req_addr, up_flush, down_req_ready, down_resp_valid,
           down_resp_data,
    output up_req_ready, up_resp_valid, up_resp_data, down_req_valid, down_req_addr
  );

  // Fetch unit plus memory side.
  modport master (
    output up_req_valid, up_req_addr, up_flush, down_req_ready, down_resp_valid,
           down_resp_data,
    input  up_req_ready, up_resp_valid, up_resp_data, down_req_valid, down_req_addr
  );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: one synchronous read port, one fill write port and a
// whole-cache flush that also wins over a coincident fill's valid bit.
module icache_array
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_data,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [LINE_W-1:0] o_rd_data
);

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_data [SETS];
  logic              r_rd_valid;
  logic [TAG_W-1:0]  r_rd_tag;
  logic [LINE_W-1:0] r_rd_data;

  // Reads sample pre-update contents, so a read alongside a flush sees old valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (i_rd_en) r_rd_valid <= r_valid[i_rd_idx];
      if (i_flush) begin
        r_valid <= '0;
      end else if (i_wr_en) begin
        r_valid[i_wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_tag  <= r_tag[i_rd_idx];
      r_rd_data <= r_data[i_rd_idx];
    end
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_tag   = r_rd_tag;
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/icache_top.sv
// Blocking direct-mapped instruction cache: lookup FSM, refill sequencing and
// response muxing around icache_array.
module icache_top
  import icache_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  icache_if.slave   bus
);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_e            r_state;
  state_e            w_state_next;
  addr_t             r_addr;
  addr_t             r_down_addr;
  logic [DATA_W-1:0] r_fill_word;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              w_resp_valid_next;
  logic [DATA_W-1:0] w_resp_data_next;

  logic              w_accept;
  logic              w_hit;
  logic              w_fill;
  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [LINE_W-1:0] w_rd_data;
  logic [SEL_W-1:0]  w_sel;
  logic [DATA_W-1:0] w_hit_word;
  logic [DATA_W-1:0] w_fill_word;
  logic              w_unused_addr;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_hit    = w_rd_valid && (w_rd_tag == get_tag(r_addr));
  assign w_fill   = (r_state == StMissWait) && bus.down_resp_valid;
  assign w_accept = bus.up_req_valid && bus.up_req_ready;
  assign w_sel    = {get_word(r_addr), {BSEL_W{1'b0}}};

  assign w_hit_word  = w_rd_data[w_sel +: DATA_W];
  assign w_fill_word = bus.down_resp_data[w_sel +: DATA_W];

  assign bus.up_req_ready   = w_rst_n &&
                              ((r_state == StIdle) || ((r_state == StLookup) && w_hit));
  assign bus.up_resp_valid  = r_resp_valid;
  assign bus.up_resp_data   = r_resp_data;
  assign bus.down_req_valid = (r_state == StMissReq);
  assign bus.down_req_addr  = r_down_addr;

  assign w_unused_addr = ^{bus.up_req_addr[1:0], r_addr[1:0]};

  always_comb begin
    w_state_next      = r_state;
    w_resp_valid_next = 1'b0;
    w_resp_data_next  = r_resp_data;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = StLookup;
      end
      StLookup: begin
        if (w_hit) begin
          w_resp_valid_next = 1'b1;
          w_resp_data_next  = w_hit_word;
          w_state_next      = w_accept ? StLookup : StIdle;
        end else begin
          w_state_next = StMissReq;
        end
      end
      StMissReq: begin
        if (bus.down_req_ready) w_state_next = StMissWait;
      end
      StMissWait: begin
        if (bus.down_resp_valid) w_state_next = StResp;
      end
      StResp: begin
        w_resp_valid_next = 1'b1;
        w_resp_data_next  = r_fill_word;
        w_state_next      = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_down_addr  <= '0;
      r_fill_word  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_data  <= w_resp_data_next;
      if (w_accept) r_addr <= bus.up_req_addr;
      if ((r_state == StLookup) && !w_hit) r_down_addr <= line_addr(r_addr);
      // Requested word comes straight from the returned line, not the array.
      if (w_fill) r_fill_word <= w_fill_word;
    end
  end

  icache_array u_array (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .i_rd_en    (w_accept),
    .i_rd_idx   (get_idx(bus.up_req_addr)),
    .i_flush    (bus.up_flush),
    .i_wr_en    (w_fill),
    .i_wr_idx   (get_idx(r_addr)),
    .i_wr_tag   (get_tag(r_addr)),
    .i_wr_data  (bus.down_resp_data),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data)
  );

endmodule

// File: tb/tb_icache_top.sv
// Directed bench for icache_top: stimulus pushes expected words into a queue and a
// negedge monitor pops and compares every up_resp_valid pulse.
module tb_icache_top;
  import icache_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   last_cyc;
  int   prev_cyc;
  int   n_down;
  logic [31:0] exp_q[$];

  icache_if u_if();

  icache_top u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (u_if.down_req_valid && u_if.down_req_ready) n_down = n_down + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (u_if.up_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec = n_vec + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_resp: got %h, want no response", u_if.up_resp_data);
      end else begin
        chk("resp_data", u_if.up_resp_data, exp_q.pop_front());
      end
      prev_cyc = last_cyc;
      last_cyc = cyc;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] exp, input bit push);
    int n;
    n = 0;
    u_if.up_req_valid = 1'b1;
    u_if.up_req_addr  = a;
    #1;
    while (!u_if.up_req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_accepted", {31'd0, u_if.up_req_ready}, 32'd1);
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    u_if.up_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_arrived", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic serve_miss(input logic [31:0] exp_addr, input int stall, input int n_resp,
                            input logic [31:0] base, input logic flush_fill);
    int          n;
    int          c_hs;
    logic [255:0] line;
    n = 0;
    while (!u_if.down_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("miss_req_seen", {31'd0, u_if.down_req_valid}, 32'd1);
    if (!u_if.down_req_valid) return;
    chk("down_req_addr", u_if.down_req_addr, exp_addr);
    chk("ready_low_miss", {31'd0, u_if.up_req_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, u_if.down_req_valid}, 32'd1);
      chk("stall_addr", u_if.down_req_addr, exp_addr);
      chk("stall_ready", {31'd0, u_if.up_req_ready}, 32'd0);
    end
    u_if.down_req_ready = 1'b1;
    c_hs = cyc;
    @(negedge clk);
    u_if.down_req_ready = 1'b0;
    repeat (n_resp - 1) @(negedge clk);
    for (int k = 0; k < 8; k++) line[32*k +: 32] = base + k;
    u_if.down_resp_valid = 1'b1;
    u_if.down_resp_data  = line;
    u_if.up_flush        = flush_fill;
    @(negedge clk);
    u_if.down_resp_valid = 1'b0;
    u_if.up_flush        = 1'b0;
    drain();
    chk("miss_latency", last_cyc - c_hs, n_resp + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    n_vec = 0; n_err = 0; cyc = 0; last_cyc = 0; prev_cyc = 0; n_down = 0;
    rst_n = 1'b0;
    u_if.up_req_valid    = 1'b0;
    u_if.up_req_addr     = '0;
    u_if.up_flush        = 1'b0;
    u_if.down_req_ready  = 1'b0;
    u_if.down_resp_valid = 1'b0;
    u_if.down_resp_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'd0, u_if.up_resp_valid}, 32'd0);
    chk("rst_resp_data", u_if.up_resp_data, 32'd0);
    chk("rst_down_valid", {31'd0, u_if.down_req_valid}, 32'd0);
    chk("rst_down_addr", u_if.down_req_addr, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_after_rst", {31'd0, u_if.up_req_ready}, 32'd1);

    // Cold miss, then back-to-back hits on the filled line.
    send(32'h0000_1004, 32'hA000_0001, 1'b1);
    serve_miss(32'h0000_1000, 0, 1, 32'hA000_0000, 1'b0);
    d0 = n_down;
    send(32'h0000_1000, 32'hA000_0000, 1'b1);
    send(32'h0000_101C, 32'hA000_0007, 1'b1);
    drain();
    chk("hits_back_to_back", last_cyc - prev_cyc, 1);
    chk("hits_no_down_req", n_down - d0, 0);

    // Conflict on set 0 evicts the first line.
    send(32'h0000_1800, 32'hA000_8000, 1'b1);
    serve_miss(32'h0000_1800, 0, 2, 32'hA000_8000, 1'b0);
    send(32'h0000_1000, 32'hA000_0000, 1'b1);
    serve_miss(32'h0000_1000, 0, 1, 32'hA000_0000, 1'b0);

    // Memory stalls the request for 5 cycles.
    send(32'h0000_1804, 32'hA000_8001, 1'b1);
    serve_miss(32'h0000_1800, 5, 3, 32'hA000_8000, 1'b0);

    // Flush between fills, then flush coincident with a fill.
    @(negedge clk); u_if.up_flush = 1'b1;
    @(negedge clk); u_if.up_flush = 1'b0;
    send(32'h0000_1800, 32'hA000_8000, 1'b1);
    serve_miss(32'h0000_1800, 0, 1, 32'hA000_8000, 1'b0);
    send(32'h0000_1008, 32'hA000_0002, 1'b1);
    serve_miss(32'h0000_1000, 0, 1, 32'hA000_0000, 1'b1);
    send(32'h0000_1008, 32'hA000_0002, 1'b1);
    serve_miss(32'h0000_1000, 0, 1, 32'hA000_0000, 1'b0);
    d0 = n_down;
    send(32'h0000_100C, 32'hA000_0003, 1'b1);
    drain();
    chk("hit_after_refill", n_down - d0, 0);

    // Reset while waiting for the line; responses during and after reset are dropped.
    send(32'h0000_2000, 32'h0, 1'b0);
    n = 0;
    while (!u_if.down_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_miss_req_seen", {31'd0, u_if.down_req_valid}, 32'd1);
    u_if.down_req_ready = 1'b1;
    @(negedge clk);
    u_if.down_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", {31'd0, u_if.up_resp_valid}, 32'd0);
    chk("midrst_resp_data", u_if.up_resp_data, 32'd0);
    chk("midrst_down_valid", {31'd0, u_if.down_req_valid}, 32'd0);
    chk("midrst_down_addr", u_if.down_req_addr, 32'd0);
    @(negedge clk);
    u_if.down_resp_valid = 1'b1;
    u_if.down_resp_data  = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    u_if.down_resp_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    u_if.down_resp_valid = 1'b1;
    @(negedge clk);
    u_if.down_resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_ready", {31'd0, u_if.up_req_ready}, 32'd1);
    chk("postrst_resp_valid", {31'd0, u_if.up_resp_valid}, 32'd0);
    chk("postrst_down_valid", {31'd0, u_if.down_req_valid}, 32'd0);
    chk("postrst_resp_data", u_if.up_resp_data, 32'd0);
    send(32'h0000_2004, 32'hB000_0001, 1'b1);
    serve_miss(32'h0000_2000, 0, 1, 32'hB000_0000, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
